// File: rtl/neda_pkg.sv
// Shared types and constants for the NEDA UART/FIR stream bridge.
// Frame header insertion is enabled by NEDA_FRAME_HDR_EN.
package neda_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  localparam logic [7:0] NEDA_HDR_BYTE = 8'hA5;
  localparam int UART_BYTE_W = 8;

  function automatic int out_bytes(input int out_w);
    return (out_w + UART_BYTE_W - 1) / UART_BYTE_W;
  endfunction

endpackage

// File: rtl/neda_byte_serializer.sv
// Result hold register and MSB-first byte issue over valid/ready.
// With NEDA_FRAME_HDR_EN defined each frame is prefixed by a header byte.
module neda_byte_serializer
  import neda_pkg::*;
#(
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OUT_W-1:0] y_in,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             done
);

  localparam int NB = out_bytes(OUT_W);
`ifdef NEDA_FRAME_HDR_EN
  localparam int TOT = NB + 1;
`else
  localparam int TOT = NB;
`endif
  localparam int HW = TOT * UART_BYTE_W;
  localparam int IW = $clog2(TOT + 1);

  logic [HW-1:0] hold;
  logic [HW-1:0] frame;
  logic [IW-1:0] byte_idx;
  logic          valid;
  logic          hs;

`ifdef NEDA_FRAME_HDR_EN
  assign frame = {NEDA_HDR_BYTE, (NB*UART_BYTE_W)'(y_in)};
`else
  assign frame = (NB*UART_BYTE_W)'(y_in);
`endif

  assign hs       = valid & tx_ready;
  assign done     = hs && (byte_idx == IW'(TOT - 1));
  assign tx_valid = valid;
  // Current byte always sits in the top lane; shifted out on handshake.
  assign tx_data  = hold[HW-1 -: UART_BYTE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold     <= '0;
      byte_idx <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      hold     <= frame;
      byte_idx <= '0;
      valid    <= 1'b1;
    end else if (hs) begin
      hold     <= hold << UART_BYTE_W;
      byte_idx <= byte_idx + IW'(1);
      if (done)
        valid <= 1'b0;
    end
  end

endmodule

// File: rtl/neda_stream_bridge.sv
// UART byte stream to NEDA FIR core bridge: delay line, latency wait, FSM.
// Optional frame header via NEDA_FRAME_HDR_EN (see neda_byte_serializer).
module neda_stream_bridge
  import neda_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TAPS     = 8,
  parameter int OUT_W    = 24,
  parameter int CALC_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [TAPS*DATA_W-1:0] x_bus,
  input  logic [OUT_W-1:0]       y_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   overrun
);

  localparam int LW = $clog2(CALC_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(CALC_LAT - 1);

  state_t          state, state_d;
  logic [LW-1:0]   lat_cnt, lat_d;
  logic            load;
  logic            ovr_set;
  logic            done;
  logic [DATA_W-1:0] sample;

  assign sample = DATA_W'(rx_data);

  generate
    if (TAPS == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n)
          x_bus <= '0;
        else if (rx_valid)
          x_bus <= sample;
      end
    end else begin : g_line
      always_ff @(posedge clk) begin
        if (!rst_n)
          x_bus <= '0;
        else if (rx_valid)
          x_bus <= {x_bus[(TAPS-1)*DATA_W-1:0], sample};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_d;
      if (ovr_set)
        overrun <= 1'b1;
    end
  end

  // A sample landing on the last-byte handshake chains straight into WAIT.
  always_comb begin
    state_d = state;
    lat_d   = lat_cnt;
    load    = 1'b0;
    ovr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          state_d = WAIT;
          lat_d   = '0;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          load    = 1'b1;
          state_d = SEND;
        end else begin
          lat_d = lat_cnt + LW'(1);
        end
        if (rx_valid)
          ovr_set = 1'b1;
      end
      SEND: begin
        if (done) begin
          if (rx_valid) begin
            state_d = WAIT;
            lat_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (rx_valid) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  neda_byte_serializer #(
    .OUT_W(OUT_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .y_in    (y_in),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .done    (done)
  );

endmodule

// File: tb/tb_neda_stream_bridge.sv
// Directed self-checking bench for neda_stream_bridge (default and
// OUT_W=20/TAPS=4 instances; expectations follow NEDA_FRAME_HDR_EN).
module tb_neda_stream_bridge;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [63:0] x_bus;
  logic [23:0] y_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;

  logic        rx_valid1;
  logic [31:0] x_bus1;
  logic [19:0] y1;
  logic [7:0]  tx_data1;
  logic        tx_valid1;
  logic        tx_ready1;
  logic        busy1;
  logic        overrun1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int hs;
  int n0;
  logic [7:0] e0[$];
  logic [7:0] e1[$];

  neda_stream_bridge u0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .x_bus   (x_bus),
    .y_in    (y_in),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .overrun (overrun)
  );

  neda_stream_bridge #(
    .DATA_W  (8),
    .TAPS    (4),
    .OUT_W   (20),
    .CALC_LAT(4)
  ) u1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid1),
    .x_bus   (x_bus1),
    .y_in    (y1),
    .tx_data (tx_data1),
    .tx_valid(tx_valid1),
    .tx_ready(tx_ready1),
    .busy    (busy1),
    .overrun (overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef NEDA_FRAME_HDR_EN
    e0 = {8'hA5, 8'hAB, 8'hCD, 8'hEF};
    e1 = {8'hA5, 8'h0F, 8'hFF, 8'hFF};
`else
    e0 = {8'hAB, 8'hCD, 8'hEF};
    e1 = {8'h0F, 8'hFF, 8'hFF};
`endif
    n0 = e0.size();

    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    y_in      = '0;
    tx_ready  = 1'b1;
    rx_valid1 = 1'b0;
    y1        = '0;
    tx_ready1 = 1'b1;

    // reset
    tick();
    tick();
    chk("rst_x_bus", x_bus, 64'h0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // delay-line order
    for (int i = 1; i <= 9; i++) begin
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (i == 8) chk("line_8", x_bus, 64'h0102030405060708);
      if (i == 9) chk("line_9", x_bus, 64'h0203040506070809);
      repeat (19) tick();
    end
    chk("line_no_overrun", overrun, 1'b0);
    chk("line_idle", busy, 1'b0);

    // single frame, y_in valid only across the 4th edge
    rx_data  = 8'h10;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("sf_busy", busy, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      y_in = (k == 4) ? 24'hABCDEF : 24'h123456;
      if (k == 4) chk("sf_wait_no_valid", tx_valid, 1'b0);
      tick();
    end
    y_in = 24'h000000;
    for (int b = 0; b < n0; b++) begin
      chk("sf_valid", tx_valid, 1'b1);
      chk("sf_byte", tx_data, e0[b]);
      tick();
    end
    chk("sf_end_valid", tx_valid, 1'b0);
    chk("sf_end_busy", busy, 1'b0);

    // backpressure
    y_in     = 24'hABCDEF;
    tx_ready = 1'b0;
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (4) tick();
    for (int s = 0; s < 5; s++) begin
      chk("bp_hold_valid", tx_valid, 1'b1);
      chk("bp_hold_data", tx_data, e0[0]);
      tick();
    end
    tx_ready = 1'b1;
    for (int b = 0; b < n0; b++) begin
      chk("bp_byte", tx_data, e0[b]);
      tick();
    end
    chk("bp_end_valid", tx_valid, 1'b0);

    // back-to-back: rx exactly on last-byte handshake
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (4) tick();
    repeat (n0 - 1) tick();
    chk("b2b_last_byte", tx_data, e0[n0-1]);
    rx_data  = 8'h13;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("b2b_wait_busy", busy, 1'b1);
    chk("b2b_wait_valid", tx_valid, 1'b0);
    chk("b2b_overrun", overrun, 1'b0);
    repeat (3) tick();
    chk("b2b_lat_not_early", tx_valid, 1'b0);
    tick();
    chk("b2b_second_valid", tx_valid, 1'b1);
    chk("b2b_second_byte", tx_data, e0[0]);
    repeat (n0) tick();
    chk("b2b_drain", tx_valid, 1'b0);
    chk("b2b_overrun_end", overrun, 1'b0);

    // overrun: rx during WAIT, count not restarted, one frame only
    rx_data  = 8'h14;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    rx_data  = 8'h15;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_shift", x_bus[15:0], 16'h1415);
    tick();
    tick();
    chk("ovr_no_restart", tx_valid, 1'b1);
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid && tx_ready) hs++;
      tick();
    end
    chk("ovr_one_frame", 64'(hs), 64'(n0));
    chk("ovr_sticky", overrun, 1'b1);

    // OUT_W=20, TAPS=4 instance; reset mid-SEND
    rx_data   = 8'h33;
    y1        = 20'hFFFFF;
    rx_valid1 = 1'b1;
    tick();
    rx_valid1 = 1'b0;
    chk("p_x_bus", x_bus1, 32'h00000033);
    repeat (4) tick();
    chk("p_byte0", tx_data1, e1[0]);
    tick();
    chk("p_byte1", tx_data1, e1[1]);
    chk("p_valid1", tx_valid1, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("p_rst_valid", tx_valid1, 1'b0);
    chk("p_rst_busy", busy1, 1'b0);
    chk("p_rst_x_bus", x_bus1, 32'h0);
    chk("p_rst_ovr_u0", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("p_no_more_bytes", tx_valid1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
